// File: rtl/xilly_pkg.sv
// Shared Xillybus definitions: stream word width, default FIFO depth and the
// word type used by the loopback FIFO slice.
// Related build option: XILLY_FIFO_COUNT_EN (exposes occupancy on the top).
package xilly_pkg;

   localparam int XILLY_WIDTH           = 32;
   localparam int XILLY_FIFO_DEPTH_LOG2 = 9;

   typedef logic [XILLY_WIDTH-1:0] xilly_word_t;

endpackage

// File: rtl/xilly_loopback_fifo_if.sv
// Xillybus write_32/read_32 stream pair as seen by the user logic.
// master: the Xillybus core side (drives strobes, data and open flags).
// slave : the user FIFO side (drives full, empty and read data).
interface xilly_loopback_fifo_if;
   import xilly_pkg::*;

   logic        user_w_write_32_wren;
   xilly_word_t user_w_write_32_data;
   logic        user_w_write_32_full;
   logic        user_w_write_32_open;
   logic        user_r_read_32_rden;
   xilly_word_t user_r_read_32_data;
   logic        user_r_read_32_empty;
   logic        user_r_read_32_open;

   modport master (
      output user_w_write_32_wren,
      output user_w_write_32_data,
      output user_w_write_32_open,
      output user_r_read_32_rden,
      output user_r_read_32_open,
      input  user_w_write_32_full,
      input  user_r_read_32_data,
      input  user_r_read_32_empty
   );

   modport slave (
      input  user_w_write_32_wren,
      input  user_w_write_32_data,
      input  user_w_write_32_open,
      input  user_r_read_32_rden,
      input  user_r_read_32_open,
      output user_w_write_32_full,
      output user_r_read_32_data,
      output user_r_read_32_empty
   );

endinterface

// File: rtl/xilly_sync_fifo.sv
// Generic single-clock FIFO, standard (non-FWFT) read with one cycle latency.
// Registered empty/full flags derived from an occupancy counter, synchronous
// flush with priority over traffic, asynchronous active-high reset.
// The count output is always present; the top decides whether to export it
// (XILLY_FIFO_COUNT_EN).
module xilly_sync_fifo
   import xilly_pkg::*;
#(
   parameter int DEPTH_LOG2 = XILLY_FIFO_DEPTH_LOG2,
   parameter int WIDTH      = XILLY_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                    DEPTH      = 1 << DEPTH_LOG2;
   localparam int                    CW         = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [CW-1:0]         count_next;

   // Accept decisions use the registered flags, so a full/empty seen at the
   // edge wins over a same-cycle strobe.
   always_comb begin
      // NOTE: combinational blocks use blocking assignments and assign every
      // variable on every path, so no latch is inferred.
      wr_acc     = wr_en && !full;
      rd_acc     = rd_en && !empty;
      count_next = count + CW'(wr_acc) - CW'(rd_acc);
   end

   // Storage write port; pointers below guarantee no read/write collision.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; only pointers and flags define
      // which entries are valid, so clearing it would be wasted logic.
      if (!flush && wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy, registered flags and the read data register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            rd_data <= mem[rd_ptr];
         end
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == FULL_COUNT);
      end
   end

endmodule

// File: rtl/xilly_loopback_fifo.sv
// Loopback buffer behind the Xillybus write_32/read_32 stream pair: words
// written by the host come back in order on the read stream.
// The FIFO is flushed whenever the host has both device files closed.
// Build option: define XILLY_FIFO_COUNT_EN to add the user_fifo_count port.
module xilly_loopback_fifo
   import xilly_pkg::*;
#(
   parameter int DEPTH_LOG2 = XILLY_FIFO_DEPTH_LOG2
)
(
   input  logic                  bus_clk,
   input  logic                  quiesce,
   xilly_loopback_fifo_if.slave  bus
`ifdef XILLY_FIFO_COUNT_EN
   ,
   output logic [DEPTH_LOG2:0]   user_fifo_count
`endif
);

   logic flush;
`ifndef XILLY_FIFO_COUNT_EN
   logic [DEPTH_LOG2:0] count_unused;
`endif

   // Both files closed means no session is active: drop any leftover words.
   always_comb begin
      flush = !bus.user_w_write_32_open && !bus.user_r_read_32_open;
   end

   xilly_sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (XILLY_WIDTH)
   ) u_fifo (
      .clk     (bus_clk),
      .rst     (quiesce),
      .flush   (flush),
      .wr_en   (bus.user_w_write_32_wren),
      .wr_data (bus.user_w_write_32_data),
      .rd_en   (bus.user_r_read_32_rden),
      .rd_data (bus.user_r_read_32_data),
      .full    (bus.user_w_write_32_full),
      .empty   (bus.user_r_read_32_empty),
`ifdef XILLY_FIFO_COUNT_EN
      .count   (user_fifo_count)
`else
      .count   (count_unused)
`endif
   );

endmodule

// File: tb/tb_xilly_loopback_fifo.sv
// Self-checking bench for xilly_loopback_fifo.
// Reference model: a queue of stored words; a scoreboard queue carries the
// word each accepted read must return, popped by an independent monitor.
// Optional: XILLY_FIFO_COUNT_EN also checks user_fifo_count.
module tb_xilly_loopback_fifo;
   import xilly_pkg::*;

   localparam int DEPTH_LOG2 = XILLY_FIFO_DEPTH_LOG2;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic bus_clk = 1'b0;
   logic quiesce = 1'b1;

   xilly_loopback_fifo_if fifo_if ();

`ifdef XILLY_FIFO_COUNT_EN
   logic [DEPTH_LOG2:0] user_fifo_count;
`endif

   xilly_loopback_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .bus_clk (bus_clk),
      .quiesce (quiesce),
      .bus     (fifo_if)
`ifdef XILLY_FIFO_COUNT_EN
      ,
      .user_fifo_count (user_fifo_count)
`endif
   );

   always #5 bus_clk = ~bus_clk;

   int n_checks = 0;
   int n_errors = 0;

   xilly_word_t model_q [$];   // words currently held by the FIFO
   xilly_word_t exp_q   [$];   // words the next read_data update must show
   xilly_word_t held = '0;     // value read_data must be holding

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO semantics on a plain queue, evaluated at each edge.
   always @(posedge bus_clk or posedge quiesce) begin : model
      bit was_empty;
      bit was_full;
      if (quiesce) begin
         model_q.delete();
         exp_q.delete();
         held = '0;
      end else if (!fifo_if.user_w_write_32_open && !fifo_if.user_r_read_32_open) begin
         model_q.delete();
      end else begin
         was_empty = (model_q.size() == 0);
         was_full  = (model_q.size() == DEPTH);
         if (fifo_if.user_r_read_32_rden && !was_empty) exp_q.push_back(model_q.pop_front());
         if (fifo_if.user_w_write_32_wren && !was_full) model_q.push_back(fifo_if.user_w_write_32_data);
      end
   end

   // Monitor: compare outputs mid-cycle against the scoreboard and model.
   always @(negedge bus_clk) begin
      if (exp_q.size() != 0) held = exp_q.pop_front();
      check("read_data", fifo_if.user_r_read_32_data, held);
      check("empty", 32'(fifo_if.user_r_read_32_empty), 32'(model_q.size() == 0));
      check("full",  32'(fifo_if.user_w_write_32_full), 32'(model_q.size() == DEPTH));
`ifdef XILLY_FIFO_COUNT_EN
      check("count", 32'(user_fifo_count), 32'(model_q.size()));
`endif
   end

   // One clock of stimulus, applied at a falling edge.
   task automatic step(input logic we, input xilly_word_t d, input logic re);
      fifo_if.user_w_write_32_wren = we;
      fifo_if.user_w_write_32_data = d;
      fifo_if.user_r_read_32_rden  = re;
      @(negedge bus_clk);
   endtask

   initial begin
      fifo_if.user_w_write_32_wren = 1'b0;
      fifo_if.user_w_write_32_data = '0;
      fifo_if.user_r_read_32_rden  = 1'b0;
      fifo_if.user_w_write_32_open = 1'b1;
      fifo_if.user_r_read_32_open  = 1'b1;

      // Reset state held for five clocks, then released.
      repeat (5) @(negedge bus_clk);
      check("rst_empty", 32'(fifo_if.user_r_read_32_empty), 32'd1);
      check("rst_full",  32'(fifo_if.user_w_write_32_full), 32'd0);
      check("rst_data",  fifo_if.user_r_read_32_data, 32'd0);
      quiesce = 1'b0;
      step(1'b0, '0, 1'b0);
      check("rel_empty", 32'(fifo_if.user_r_read_32_empty), 32'd1);
      check("rel_full",  32'(fifo_if.user_w_write_32_full), 32'd0);

      // Three writes then three reads.
      for (int i = 1; i <= 3; i++) step(1'b1, xilly_word_t'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("small_data", fifo_if.user_r_read_32_data, 32'd3);

      // Streaming write+read every cycle.
      for (int i = 0; i < 2048; i++) step(1'b1, xilly_word_t'(i), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("stream_last", fifo_if.user_r_read_32_data, 32'd2047);

      // Fill to capacity, attempt an overflow, drain, attempt an underflow.
      for (int i = 0; i < DEPTH; i++) step(1'b1, xilly_word_t'(i), 1'b0);
      check("fill_full", 32'(fifo_if.user_w_write_32_full), 32'd1);
      step(1'b1, 32'hDEAD, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
      check("drain_empty", 32'(fifo_if.user_r_read_32_empty), 32'd1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("underflow_hold", fifo_if.user_r_read_32_data, 32'(DEPTH - 1));

      // Flush by closing both files for one clock.
      for (int i = 0; i < 10; i++) step(1'b1, xilly_word_t'(32'h200 + i), 1'b0);
      fifo_if.user_w_write_32_open = 1'b0;
      fifo_if.user_r_read_32_open  = 1'b0;
      step(1'b0, '0, 1'b0);
      fifo_if.user_w_write_32_open = 1'b1;
      fifo_if.user_r_read_32_open  = 1'b1;
      check("flush_empty", 32'(fifo_if.user_r_read_32_empty), 32'd1);
      check("flush_keep",  fifo_if.user_r_read_32_data, 32'(DEPTH - 1));
`ifdef XILLY_FIFO_COUNT_EN
      check("flush_count", 32'(user_fifo_count), 32'd0);
`endif
      step(1'b1, 32'hA5A5A5A5, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("after_flush", fifo_if.user_r_read_32_data, 32'hA5A5A5A5);

      // Asynchronous reset pulse in the middle of traffic.
      for (int i = 0; i < 5; i++) step(1'b1, xilly_word_t'(32'h300 + i), 1'b0);
      for (int i = 5; i < 10; i++) step(1'b1, xilly_word_t'(32'h300 + i), 1'b1);
      @(posedge bus_clk);
      #2 quiesce = 1'b1;
      #1;
      check("async_empty", 32'(fifo_if.user_r_read_32_empty), 32'd1);
      check("async_full",  32'(fifo_if.user_w_write_32_full), 32'd0);
      check("async_data",  fifo_if.user_r_read_32_data, 32'd0);
      @(negedge bus_clk);
      step(1'b0, '0, 1'b0);
      quiesce = 1'b0;
      for (int i = 0; i < 16; i++) step(1'b1, xilly_word_t'(32'h400 + i), 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("restart_last", fifo_if.user_r_read_32_data, 32'h40F);

      // Random traffic: write-heavy then read-heavy, occasional file closes.
      for (int i = 0; i < 3000; i++) begin
         int          r;
         logic        we;
         logic        re;
         r = int'($urandom_range(0, 99));
         fifo_if.user_w_write_32_open = (r != 0) && (r != 1);
         fifo_if.user_r_read_32_open  = (r != 0) && (r != 2);
         if (i < 1500) begin
            we = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) == 0);
         end else begin
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) != 0);
         end
         step(we, xilly_word_t'($urandom), re);
      end
      fifo_if.user_w_write_32_open = 1'b1;
      fifo_if.user_r_read_32_open  = 1'b1;
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
